// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority stream multiplexer.
package stream_mux_rr_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 32'sd1;
        end
        return (r < 32'sd1) ? 32'sd1 : r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational N-way arbiter: rotating-start round-robin or lowest-index-first.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int N  = 8,
    parameter int RR = 1,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    // Channel visited at scan step k; an out-of-range pointer restarts at 0.
    function automatic int scan_idx(input int p, input int k);
        int s;
        if (RR == int'(ARB_RR)) begin
            s = ((p >= N) ? 32'sd0 : p) + k;
            if (s >= N) begin
                s = s - N;
            end else begin
                s = s;
            end
        end else begin
            s = k;
        end
        return s;
    endfunction

    // First requesting channel in scan order wins; grant is gated by en.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[scan_idx(int'(ptr), k)]) begin
                any     = 1'b1;
                gnt_idx = SELW'(scan_idx(int'(ptr), k));
            end else begin
                any = any;
            end
        end
        if (en && any) begin
            gnt[gnt_idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-way valid/ready stream multiplexer with one registered output stage.
// Optional packet lock (in_last/out_last) enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int RR    = 1,
    localparam int SELW = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [N-1:0]         in_last,
    output logic                 out_last,
`endif
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [SELW-1:0] ptr_r;
    logic [N-1:0]    req_s;
    logic [N-1:0]    gnt_s;
    logic [SELW-1:0] gnt_idx_s;
    logic [SELW-1:0] ptr_next_s;
    logic            any_s;
    logic            load_s;
    logic            en_s;
    logic            xfer_s;

`ifdef STREAM_MUX_LOCK_EN
    logic            locked_r;
    logic [SELW-1:0] lock_idx_r;

    // While a packet is open only its owner may request.
    always_comb begin
        req_s = '0;
        if (locked_r) begin
            req_s[lock_idx_r] = in_valid[lock_idx_r];
        end else begin
            req_s = in_valid;
        end
    end
`else
    assign req_s = in_valid;
`endif

    assign load_s     = !out_valid || out_ready;
    assign en_s       = load_s && rst_n;
    assign xfer_s     = en_s && any_s;
    assign in_ready   = gnt_s;
    assign ptr_next_s = (gnt_idx_s == SELW'(N - 1)) ? '0 : gnt_idx_s + SELW'(1);

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .req     (req_s),
        .ptr     (ptr_r),
        .en      (en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // Output register and pointer; pointer moves only when a beat (or packet) completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            ptr_r      <= '0;
`ifdef STREAM_MUX_LOCK_EN
            out_last   <= 1'b0;
            locked_r   <= 1'b0;
            lock_idx_r <= '0;
`endif
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
            out_sel   <= gnt_idx_s;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= in_last[gnt_idx_s];
            if (in_last[gnt_idx_s]) begin
                locked_r <= 1'b0;
                ptr_r    <= ptr_next_s;
            end else begin
                locked_r   <= 1'b1;
                lock_idx_r <= gnt_idx_s;
            end
`else
            ptr_r     <= ptr_next_s;
`endif
        end else if (load_s) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: N=8 round-robin, N=5 wrap, N=8 fixed priority.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   v8, r8;
    logic [255:0] d8;
    logic         ov8, or8;
    logic [31:0]  od8;
    logic [2:0]   os8;

    logic [4:0]   v5, r5;
    logic [159:0] d5;
    logic         ov5, or5;
    logic [31:0]  od5;
    logic [2:0]   os5;

    logic [7:0]   vf, rf;
    logic [255:0] df;
    logic         ovf, orf;
    logic [31:0]  odf;
    logic [2:0]   osf;

`ifdef STREAM_MUX_LOCK_EN
    logic [7:0] l8, lf;
    logic [4:0] l5;
    logic       ol8, ol5, olf;
`endif

    stream_mux_rr #(.WIDTH(32), .N(8), .RR(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_data(d8), .in_ready(r8),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(l8), .out_last(ol8),
`endif
        .out_valid(ov8), .out_data(od8), .out_sel(os8), .out_ready(or8)
    );

    stream_mux_rr #(.WIDTH(32), .N(5), .RR(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_data(d5), .in_ready(r5),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(l5), .out_last(ol5),
`endif
        .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(or5)
    );

    stream_mux_rr #(.WIDTH(32), .N(8), .RR(0)) dutf (
        .clk(clk), .rst_n(rst_n), .in_valid(vf), .in_data(df), .in_ready(rf),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(lf), .out_last(olf),
`endif
        .out_valid(ovf), .out_data(odf), .out_sel(osf), .out_ready(orf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 8'hFF; v5 = 5'h1F; vf = 8'hFF;
        or8 = 1'b1; or5 = 1'b1; orf = 1'b1;
        for (int i = 0; i < 8; i++) d8[i*32 +: 32] = 32'hA0 + 32'(i);
        for (int i = 0; i < 5; i++) d5[i*32 +: 32] = 32'hB0 + 32'(i);
        for (int i = 0; i < 8; i++) df[i*32 +: 32] = 32'hC0 + 32'(i);
`ifdef STREAM_MUX_LOCK_EN
        l8 = 8'hFF; l5 = 5'h1F; lf = 8'hFF;
`endif
        step();
        step();
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_out_sel",   64'(os8), 64'd0);
        chk("rst_out_data",  64'(od8), 64'd0);
        chk("rst_in_ready",  64'(r8),  64'd0);
        chk("rst_in_ready5", 64'(r5),  64'd0);

        // Round-robin fairness, all eight channels valid.
        rst_n = 1'b1; v5 = 5'h00; vf = 8'h00;
        #1;
        for (int k = 0; k < 9; k++) begin
            chk("rr_in_ready", 64'(r8), 64'(8'h01 << (k % 8)));
            step();
            chk("rr_out_valid", 64'(ov8), 64'd1);
            chk("rr_out_sel",   64'(os8), 64'(k % 8));
            chk("rr_out_data",  64'(od8), 64'(32'hA0 + 32'(k % 8)));
        end

        // Backpressure holding a beat from channel 2.
        v8 = 8'h04; d8[2*32 +: 32] = 32'hDEADBEEF;
        #1;
        chk("bp_in_ready_load", 64'(r8), 64'h04);
        step();
        chk("bp_sel_load",  64'(os8), 64'd2);
        chk("bp_data_load", 64'(od8), 64'hDEADBEEF);
        or8 = 1'b0; v8 = 8'h0F;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready_stall", 64'(r8), 64'd0);
            step();
            chk("bp_valid_stall", 64'(ov8), 64'd1);
            chk("bp_sel_stall",   64'(os8), 64'd2);
            chk("bp_data_stall",  64'(od8), 64'hDEADBEEF);
        end
        or8 = 1'b1;
        #1;
        chk("bp_ptr3_ready", 64'(r8), 64'h08);
        step();
        chk("bp_drain_sel",  64'(os8), 64'd3);
        chk("bp_drain_data", 64'(od8), 64'hA3);
        v8 = 8'h00;
        step();
        chk("idle_valid", 64'(ov8), 64'd0);
        chk("idle_sel",   64'(os8), 64'd3);
        chk("idle_data",  64'(od8), 64'hA3);

`ifdef STREAM_MUX_LOCK_EN
        // Packet lock: ch2 three-beat packet while ch0 waits (ptr would favour ch0).
        v8 = 8'h04; l8 = 8'hFB; d8[2*32 +: 32] = 32'h22220001;
        step();
        chk("lock_sel1",  64'(os8), 64'd2);
        chk("lock_last1", 64'(ol8), 64'd0);
        v8 = 8'h05; d8[2*32 +: 32] = 32'h22220002;
        #1;
        chk("lock_ready2", 64'(r8), 64'h04);
        step();
        chk("lock_sel2",  64'(os8), 64'd2);
        chk("lock_data2", 64'(od8), 64'h22220002);
        chk("lock_last2", 64'(ol8), 64'd0);
        l8 = 8'hFF; d8[2*32 +: 32] = 32'h22220003;
        #1;
        chk("lock_ready3", 64'(r8), 64'h04);
        step();
        chk("lock_sel3",  64'(os8), 64'd2);
        chk("lock_data3", 64'(od8), 64'h22220003);
        chk("lock_last3", 64'(ol8), 64'd1);
        v8 = 8'h01;
        #1;
        chk("lock_ready4", 64'(r8), 64'h01);
        step();
        chk("lock_sel4",  64'(os8), 64'd0);
        chk("lock_data4", 64'(od8), 64'hA0);
        v8 = 8'h00;
`endif

        // Non-power-of-two wrap, N=5.
        v5 = 5'h10;
        #1;
        chk("n5_ready_ch4", 64'(r5), 64'h10);
        step();
        chk("n5_sel_ch4",  64'(os5), 64'd4);
        chk("n5_data_ch4", 64'(od5), 64'hB4);
        v5 = 5'h09;
        #1;
        chk("n5_ready_ch0", 64'(r5), 64'h01);
        step();
        chk("n5_sel_ch0", 64'(os5), 64'd0);
        chk("n5_ready_ch3", 64'(r5), 64'h08);
        step();
        chk("n5_sel_ch3",  64'(os5), 64'd3);
        chk("n5_data_ch3", 64'(od5), 64'hB3);
        v5 = 5'h00;

        // Fixed priority: ch1 beats ch5 until it drops.
        vf = 8'h22;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fp_ready_ch1", 64'(rf), 64'h02);
            step();
            chk("fp_sel_ch1",  64'(osf), 64'd1);
            chk("fp_data_ch1", 64'(odf), 64'hC1);
        end
        vf = 8'h20;
        #1;
        chk("fp_ready_ch5", 64'(rf), 64'h20);
        step();
        chk("fp_sel_ch5",  64'(osf), 64'd5);
        chk("fp_data_ch5", 64'(odf), 64'hC5);
        vf = 8'h00;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
